// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control sequencer.
// Holds the FSM state encoding, instruction class codes, branch condition
// codes, ALU select codes, bus select codes and condition-flag bit indices.
package cpu_pkg;

  typedef enum logic [3:0] {
    StFetch0, StFetch1, StFetch2, StDecode,
    StOpnd0, StOpnd1, StOpnd2, StMemData,
    StStore, StExec, StBrLoad, StBrSkip,
    StHalt, StTrap
  } state_e;

  // Instruction classes, IR[7:5]
  localparam logic [2:0] ClsNop     = 3'b000;
  localparam logic [2:0] ClsLdImm   = 3'b001;
  localparam logic [2:0] ClsLdDir   = 3'b010;
  localparam logic [2:0] ClsStDir   = 3'b011;
  localparam logic [2:0] ClsAlu     = 3'b100;
  localparam logic [2:0] ClsBranch  = 3'b101;
  localparam logic [2:0] ClsIllegal = 3'b110;
  localparam logic [2:0] ClsHalt    = 3'b111;

  // Branch conditions, {IR[4:2], IR[0]}
  localparam logic [3:0] CondBra = 4'b0000;
  localparam logic [3:0] CondBmi = 4'b0001;
  localparam logic [3:0] CondBpl = 4'b0010;
  localparam logic [3:0] CondBeq = 4'b0011;
  localparam logic [3:0] CondBne = 4'b0100;
  localparam logic [3:0] CondBvs = 4'b0101;
  localparam logic [3:0] CondBvc = 4'b0110;
  localparam logic [3:0] CondBcs = 4'b0111;
  localparam logic [3:0] CondBcc = 4'b1000;

  // ALU operation select; the ALU class passes IR[4:2] straight through
  typedef logic [2:0] alu_sel_t;
  localparam alu_sel_t AluSelIdle = 3'b000;

  // Bus selects
  localparam logic [1:0] Bus1Pc   = 2'b00;
  localparam logic [1:0] Bus1Reg  = 2'b01;
  localparam logic [1:0] Bus2Alu  = 2'b00;
  localparam logic [1:0] Bus2Bus1 = 2'b01;
  localparam logic [1:0] Bus2Mem  = 2'b10;

  // Condition flag bit positions in CCR_Result
  localparam int unsigned CcrC = 0;
  localparam int unsigned CcrZ = 1;
  localparam int unsigned CcrN = 2;
  localparam int unsigned CcrV = 3;

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator (purely combinational).
//   cond_i    : {IR[4:2], IR[0]} branch condition code
//   ccr_i     : condition flags {V, N, Z, C}
//   taken_o   : condition holds for a legal code
//   illegal_o : code is not a defined branch condition
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] ccr_i,
  output logic       taken_o,
  output logic       illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (cond_i)
      CondBra: taken_o = 1'b1;
      CondBmi: taken_o = ccr_i[CcrN];
      CondBpl: taken_o = ~ccr_i[CcrN];
      CondBeq: taken_o = ccr_i[CcrZ];
      CondBne: taken_o = ~ccr_i[CcrZ];
      CondBvs: taken_o = ccr_i[CcrV];
      CondBvc: taken_o = ~ccr_i[CcrV];
      CondBcs: taken_o = ccr_i[CcrC];
      CondBcc: taken_o = ~ccr_i[CcrC];
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Control sequencer for a small accumulator-style CPU.
// Steps fetch / operand / execute phases and issues datapath strobes.
// Inputs : Clk, Reset (async, active-high), IR, CCR_Result {V,N,Z,C}, Mem_Ready.
// Outputs: IR_Load, MAR_Load, PC_Load, PC_Inc, CCR_Load, write, Reg_Load (one-hot),
//          Reg_Sel, ALU_Sel, Bus1_Sel, Bus2_Sel, and sticky Halted / Illegal / Bus_Err.
// Outputs are decoded from the state register; strobes tied to memory handshakes are
// gated by the live Mem_Ready, and everything is forced low while Reset is high.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 2,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [7:0]          IR,
  input  logic [3:0]          CCR_Result,
  input  logic                Mem_Ready,
  output logic                IR_Load,
  output logic                MAR_Load,
  output logic                PC_Load,
  output logic                PC_Inc,
  output logic                CCR_Load,
  output logic                write,
  output logic [NUM_REGS-1:0] Reg_Load,
  output logic [1:0]          Reg_Sel,
  output logic [2:0]          ALU_Sel,
  output logic [1:0]          Bus1_Sel,
  output logic [1:0]          Bus2_Sel,
  output logic                Halted,
  output logic                Illegal,
  output logic                Bus_Err
);

  // A zero timeout still needs a 1-bit counter to keep the declarations legal.
  localparam int unsigned CntW    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bus_err_q, bus_err_d;

  logic [2:0]          ir_class, ir_sub;
  logic [1:0]          ir_idx;
  logic                reg_bad, br_taken, br_illegal, wait_st, timeout;
  logic [NUM_REGS-1:0] reg_onehot;

  assign ir_class   = IR[7:5];
  assign ir_sub     = IR[4:2];
  assign ir_idx     = IR[1:0];
  assign reg_bad    = 32'(ir_idx) >= NUM_REGS;
  assign reg_onehot = NUM_REGS'(1) << ir_idx;

  cond_eval u_cond_eval (
    .cond_i    ({ir_sub, IR[0]}),
    .ccr_i     (CCR_Result),
    .taken_o   (br_taken),
    .illegal_o (br_illegal)
  );

  assign wait_st = state_q inside {StFetch2, StOpnd2, StMemData, StStore, StBrLoad};
  assign timeout = wait_st && !Mem_Ready && (MEM_TIMEOUT != 0) && (cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    bus_err_d = bus_err_q;
    if (wait_st && !Mem_Ready && (MEM_TIMEOUT != 0)) cnt_d = cnt_q + 1'b1;
    case (state_q)
      StFetch0:  state_d = StFetch1;
      StFetch1:  state_d = StFetch2;
      StFetch2:  if (Mem_Ready) state_d = StDecode;
      StDecode: begin
        case (ir_class)
          ClsNop:                      state_d = StFetch0;
          ClsLdImm, ClsLdDir, ClsStDir: state_d = reg_bad ? StTrap : StOpnd0;
          ClsAlu:                      state_d = reg_bad ? StTrap : StExec;
          ClsBranch: state_d = br_illegal ? StTrap : (br_taken ? StOpnd0 : StBrSkip);
          ClsHalt:                     state_d = StHalt;
          default:                     state_d = StTrap;
        endcase
      end
      // Taken branches latch the operand address and read it directly as the new PC.
      StOpnd0:   state_d = (ir_class == ClsBranch) ? StBrLoad : StOpnd1;
      StOpnd1:   state_d = StOpnd2;
      StOpnd2: begin
        if (Mem_Ready) begin
          case (ir_class)
            ClsLdImm: state_d = StFetch0;
            ClsLdDir: state_d = StMemData;
            default:  state_d = StStore;
          endcase
        end
      end
      StMemData, StStore, StBrLoad: if (Mem_Ready) state_d = StFetch0;
      StExec, StBrSkip:             state_d = StFetch0;
      StHalt:                       state_d = StHalt;
      StTrap:                       state_d = StTrap;
      default:                      state_d = StFetch0;
    endcase
    if (timeout) begin
      state_d   = StTrap;
      bus_err_d = 1'b1;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StFetch0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    CCR_Load = 1'b0;
    write    = 1'b0;
    Reg_Load = '0;
    Reg_Sel  = 2'b00;
    ALU_Sel  = AluSelIdle;
    Bus1_Sel = Bus1Pc;
    Bus2_Sel = Bus2Alu;
    Halted   = 1'b0;
    Illegal  = 1'b0;
    Bus_Err  = 1'b0;
    // Reset gates the decode so outputs drop asynchronously, not at the next edge.
    if (!Reset) begin
      case (state_q)
        StFetch0, StOpnd0: begin
          Bus1_Sel = Bus1Pc;
          Bus2_Sel = Bus2Bus1;
          MAR_Load = 1'b1;
        end
        StFetch1, StOpnd1, StBrSkip: PC_Inc = 1'b1;
        StFetch2: begin
          Bus2_Sel = Bus2Mem;
          IR_Load  = Mem_Ready;
        end
        StOpnd2: begin
          Bus2_Sel = Bus2Mem;
          if (ir_class == ClsLdImm) Reg_Load = reg_onehot & {NUM_REGS{Mem_Ready}};
          else MAR_Load = Mem_Ready;
        end
        StMemData: begin
          Bus2_Sel = Bus2Mem;
          Reg_Load = reg_onehot & {NUM_REGS{Mem_Ready}};
        end
        StStore: begin
          Bus1_Sel = Bus1Reg;
          Reg_Sel  = ir_idx;
          write    = 1'b1;
        end
        StExec: begin
          Reg_Sel  = ir_idx;
          Bus2_Sel = Bus2Alu;
          ALU_Sel  = ir_sub;
          Reg_Load = reg_onehot;
          CCR_Load = 1'b1;
        end
        StBrLoad: begin
          Bus2_Sel = Bus2Mem;
          PC_Load  = Mem_Ready;
          MAR_Load = Mem_Ready;
        end
        StHalt: Halted = 1'b1;
        StTrap: begin
          Illegal = ~bus_err_q;
          Bus_Err = bus_err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: each instruction is expanded into a list of
// abstract bus phases (address, increment, memory wait, execute) which are replayed
// against the DUT with randomized memory latency.
module tb_cpu_sequencer;

  localparam int unsigned NRegs = 2;
  localparam int unsigned Tmo   = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] IR = 8'h00;
  logic [3:0] CCR_Result = 4'h0;
  logic       Mem_Ready = 1'b0;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, CCR_Load, write;
  logic [1:0] Reg_Load, Reg_Sel, Bus1_Sel, Bus2_Sel;
  logic [2:0] ALU_Sel;
  logic       Halted, Illegal, Bus_Err;

  cpu_sequencer #(.NUM_REGS(NRegs), .MEM_TIMEOUT(Tmo)) dut (
    .Clk(Clk), .Reset(Reset), .IR(IR), .CCR_Result(CCR_Result), .Mem_Ready(Mem_Ready),
    .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .CCR_Load(CCR_Load), .write(write), .Reg_Load(Reg_Load), .Reg_Sel(Reg_Sel),
    .ALU_Sel(ALU_Sel), .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel),
    .Halted(Halted), .Illegal(Illegal), .Bus_Err(Bus_Err)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       ir_load, mar_load, pc_load, pc_inc, ccr_load, write;
    logic [1:0] reg_load, reg_sel;
    logic [2:0] alu_sel;
    logic [1:0] bus1_sel, bus2_sel;
    logic       halted, illegal, bus_err;
  } outs_t;

  typedef struct {
    outs_t base;   // driven every cycle of the phase
    outs_t gated;  // additionally driven in the cycle Mem_Ready is high
    bit    waits;
    int    low;    // Mem_Ready-low cycles before the handshake
    string tag;
  } step_t;

  typedef enum int {EndNext, EndHalt, EndTrap, EndBusErr} end_e;

  outs_t obs;
  assign obs = {IR_Load, MAR_Load, PC_Load, PC_Inc, CCR_Load, write, Reg_Load, Reg_Sel,
                ALU_Sel, Bus1_Sel, Bus2_Sel, Halted, Illegal, Bus_Err};

  step_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    writes_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (IR=%h t=%0t)", tag, got, want, IR, $time);
    end
  endtask

  function automatic int rand_low();
    if ($urandom_range(0, 15) == 0) return int'(Tmo) + 2;
    return int'($urandom_range(0, 3));
  endfunction

  function automatic void push(input outs_t b, input outs_t g, input bit w, input string t);
    step_t s;
    s.base = b; s.gated = g; s.waits = w; s.tag = t;
    s.low = w ? rand_low() : 0;
    exp_q.push_back(s);
  endfunction

  function automatic outs_t addr_phase();
    outs_t o = '0;
    o.mar_load = 1'b1;
    o.bus1_sel = 2'b00;
    o.bus2_sel = 2'b01;
    return o;
  endfunction

  function automatic outs_t inc_phase();
    outs_t o = '0;
    o.pc_inc = 1'b1;
    return o;
  endfunction

  function automatic outs_t mem_phase();
    outs_t o = '0;
    o.bus2_sel = 2'b10;
    return o;
  endfunction

  // Returns {legal, taken} from the branch mnemonic table.
  function automatic logic [1:0] branch_rule(input logic [3:0] c, input logic [3:0] ccr);
    logic v, n, z, cy;
    {v, n, z, cy} = ccr;
    case (c)
      4'd0: return {1'b1, 1'b1};
      4'd1: return {1'b1, n};
      4'd2: return {1'b1, ~n};
      4'd3: return {1'b1, z};
      4'd4: return {1'b1, ~z};
      4'd5: return {1'b1, v};
      4'd6: return {1'b1, ~v};
      4'd7: return {1'b1, cy};
      4'd8: return {1'b1, ~cy};
      default: return 2'b00;
    endcase
  endfunction

  function automatic end_e build(input logic [7:0] ir, input logic [3:0] ccr);
    logic [2:0] cls, sub;
    logic [1:0] idx, onehot, br;
    outs_t o, g;
    cls = ir[7:5]; sub = ir[4:2]; idx = ir[1:0];
    onehot = 2'b01 << idx;
    exp_q.delete();
    push(addr_phase(), '0, 1'b0, "fetch0");
    push(inc_phase(), '0, 1'b0, "fetch1");
    g = '0; g.ir_load = 1'b1;
    push(mem_phase(), g, 1'b1, "fetch2");
    push('0, '0, 1'b0, "decode");
    if ((cls inside {3'd1, 3'd2, 3'd3, 3'd4}) && int'(idx) >= int'(NRegs)) return EndTrap;
    case (cls)
      3'd0: return EndNext;
      3'd1, 3'd2, 3'd3: begin
        push(addr_phase(), '0, 1'b0, "opnd0");
        push(inc_phase(), '0, 1'b0, "opnd1");
        g = '0;
        if (cls == 3'd1) g.reg_load = onehot;
        else g.mar_load = 1'b1;
        push(mem_phase(), g, 1'b1, "opnd2");
        if (cls == 3'd2) begin
          g = '0; g.reg_load = onehot;
          push(mem_phase(), g, 1'b1, "memdata");
        end else if (cls == 3'd3) begin
          o = '0; o.bus1_sel = 2'b01; o.reg_sel = idx; o.write = 1'b1;
          push(o, '0, 1'b1, "store");
        end
        return EndNext;
      end
      3'd4: begin
        o = '0; o.reg_sel = idx; o.alu_sel = sub; o.reg_load = onehot; o.ccr_load = 1'b1;
        push(o, '0, 1'b0, "exec");
        return EndNext;
      end
      3'd5: begin
        br = branch_rule({sub, ir[0]}, ccr);
        if (!br[1]) return EndTrap;
        if (br[0]) begin
          push(addr_phase(), '0, 1'b0, "br_addr");
          g = '0; g.pc_load = 1'b1; g.mar_load = 1'b1;
          push(mem_phase(), g, 1'b1, "br_load");
        end else begin
          push(inc_phase(), '0, 1'b0, "br_skip");
        end
        return EndNext;
      end
      3'd7: return EndHalt;
      default: return EndTrap;
    endcase
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input outs_t e, input logic mr, input string tag);
    Mem_Ready = mr;
    #1;
    check_eq(tag, 32'(obs), 32'(e));
    if (obs.write) writes_seen++;
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Mem_Ready = 1'($urandom_range(0, 1));
    #1;
    check_eq("reset_outs", 32'(obs), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic run_steps(output int cycles, output bit bus_err);
    step_t s;
    cycles = 0;
    bus_err = 1'b0;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      if (!s.waits) begin
        cycle(s.base, 1'($urandom_range(0, 1)), s.tag);
        cycles++;
      end else if (s.low >= int'(Tmo)) begin
        repeat (Tmo) cycle(s.base, 1'b0, s.tag);
        cycles += int'(Tmo);
        bus_err = 1'b1;
        exp_q.delete();
      end else begin
        repeat (s.low) cycle(s.base, 1'b0, s.tag);
        cycle(outs_t'(s.base | s.gated), 1'b1, s.tag);
        cycles += s.low + 1;
      end
    end
  endtask

  task automatic run(input end_e how, output int cycles);
    bit    be;
    end_e  fin;
    outs_t o;
    run_steps(cycles, be);
    fin = be ? EndBusErr : how;
    if (fin != EndNext) begin
      o = '0;
      case (fin)
        EndHalt: o.halted = 1'b1;
        EndTrap: o.illegal = 1'b1;
        default: o.bus_err = 1'b1;
      endcase
      repeat (3) cycle(o, 1'($urandom_range(0, 1)), "sticky");
      do_reset();
    end
  endtask

  task automatic directed(input logic [7:0] ir, input logic [3:0] ccr, input int want,
                          input string tag);
    end_e how;
    int   cyc;
    IR = ir;
    CCR_Result = ccr;
    how = build(ir, ccr);
    foreach (exp_q[i]) exp_q[i].low = 0;
    run(how, cyc);
    check_eq(tag, 32'(cyc), 32'(want));
  endtask

  initial begin
    int    cyc;
    bit    be;
    end_e  how;
    step_t st;
    @(negedge Clk);
    do_reset();

    directed(8'h21, 4'h0, 7, "ldimm_cycles");
    directed(8'h88, 4'h0, 5, "alu_cycles");
    directed(8'hA7, 4'b0000, 5, "beq_nt_cycles");
    directed(8'hA7, 4'b0010, 6, "beq_t_cycles");
    directed(8'hA6, 4'b0100, 5, "bpl_nt_cycles");
    directed(8'h41, 4'h0, 8, "lddir_cycles");
    directed(8'hC0, 4'h0, 4, "illegal_class");
    directed(8'h23, 4'h0, 4, "illegal_reg");
    directed(8'hB3, 4'h0, 4, "illegal_cond");
    directed(8'hE0, 4'h0, 4, "halt");

    // Store with three Mem_Ready-low cycles in the write phase.
    IR = 8'h60;
    how = build(IR, CCR_Result);
    foreach (exp_q[i]) exp_q[i].low = 0;
    exp_q[exp_q.size() - 1].low = 3;
    writes_seen = 0;
    run(how, cyc);
    check_eq("st_cycles", 32'(cyc), 32'd11);
    check_eq("st_writes", 32'(writes_seen), 32'd4);

    // Instruction fetch never completes: bus error after Tmo wait cycles.
    IR = 8'h40;
    how = build(IR, CCR_Result);
    foreach (exp_q[i]) exp_q[i].low = 0;
    exp_q[2].low = 10;
    run(how, cyc);
    check_eq("timeout_cycles", 32'(cyc), 32'(2 + Tmo));

    // Reset asserted between edges while a store is writing.
    IR = 8'h61;
    how = build(IR, CCR_Result);
    foreach (exp_q[i]) exp_q[i].low = 0;
    st = exp_q.pop_back();
    run_steps(cyc, be);
    cycle(st.base, 1'b0, "store_pre_rst");
    Mem_Ready = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    check_eq("rst_mid_store", 32'(obs), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check_eq("fetch0_after_rst", 32'(obs), 32'(addr_phase()));
    directed(8'h00, 4'h0, 4, "nop_after_rst");

    for (int n = 0; n < 250; n++) begin
      IR = 8'($urandom);
      CCR_Result = 4'($urandom);
      how = build(IR, CCR_Result);
      run(how, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
